mem_read_data_decoder: RTL and testbench
========================================

# mem_read_data_decoder

Load-side counterpart of the store encoder in the MIPS32 SoC CPU. It accepts a load request from the pipeline and issues a single read request to data memory. It waits a variable number of wait states for the memory to answer, then extracts the addressed byte, halfword or word from the big-endian 32-bit memory word. The result is zero- or sign-extended, registered, and presented to writeback with a one-cycle valid pulse.

## Interface
- TIMEOUT, 16, maximum WAIT cycles without memReady before the access aborts with error; 0 disables the timeout.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- memRead  in  1  load request; sampled only in IDLE.
- offset  in  2  byte address bits [1:0] of the load.
- dataSize  in  2  0 word, 1 halfword, 2 byte, 3 illegal.
- signExt  in  1  1 sign-extend, 0 zero-extend; ignored for word.
- busy  out  1  high in WAIT and DONE; pipeline holds while high.
- memReq  out  1  read request to memory; high exactly in WAIT.
- memReady  in  1  memory data valid this cycle; meaningful only in WAIT.
- memData  in  32  memory read word.
- outData  out  32  registered decoded load result.
- dataValid  out  1  one-cycle pulse, result or error available.
- error  out  1  qualified by dataValid; access aborted, outData = 0.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE + memRead: latch offset, dataSize and signExt into request registers.
  - Legal request -> WAIT, timeout counter cleared.
  - Illegal request -> DONE with error = 1.
- Illegal requests:
  - dataSize 3 is always illegal.
  - Other misaligned cases are illegal only with the macro enabled (see Configuration).
- WAIT + memReady -> DONE; outData <= decode(memData), error <= 0.
- WAIT, no memReady:
  - Counter increments each cycle.
  - With TIMEOUT != 0 and counter == TIMEOUT-1 -> DONE, error = 1, outData = 0.
- DONE: dataValid = 1 for exactly one cycle, then unconditionally -> IDLE.
- Lane selection, big-endian, matching the write encoder:
  - Byte offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Half offset 0 -> [31:16], nonzero offset -> [15:0].
  - Word -> [31:0].
- Extension: byte/half fill the upper bits with the lane's MSB if signExt, else with zeros.
- memRead while busy: ignored, not queued.
- memReady outside WAIT: ignored.
- Request registers hold their values from acceptance until return to IDLE; input changes during WAIT have no effect.

## Timing
- Reset values:
  - State IDLE.
  - busy, memReq, dataValid, error = 0.
  - outData = 0; counter and request registers = 0.
- Cycle numbering, request sampled at cycle 0:
  - memReq is high from cycle 1.
  - memReady in cycle k (k >= 1) -> dataValid in cycle k+1.
  - Minimum latency: 2 cycles.
- Illegal request: dataValid with error in cycle 1; memReq never asserted.
- Timeout: dataValid with error in cycle TIMEOUT+1.
- memReady in the same cycle the counter hits TIMEOUT-1: memReady wins, normal data, no error.
- outData holds its value after dataValid until the next DONE.
- rst mid-operation, in any state:
  - Next cycle IDLE with all outputs at reset values.
  - The in-flight access is dropped; no dataValid.
- Back-to-back loads: the next memRead is accepted in the IDLE cycle after DONE, so the minimum spacing is 3 cycles.

## Configuration
- MEM_READ_ALIGN_CHECK_EN defined:
  - Half with offset[0] = 1 is illegal.
  - Word with offset != 0 is illegal.
  - Illegal requests take the error path; no memory request.
- MEM_READ_ALIGN_CHECK_EN undefined:
  - Only dataSize 3 is illegal.
  - Misaligned word ignores offset.
  - Misaligned half uses the "nonzero -> [15:0]" rule.

## Structure
- Shared package mem_access_pkg:
  - Size encodings SIZE_WORD = 2'd0, SIZE_HALF = 2'd1, SIZE_BYTE = 2'd2.
  - FSM state encoding for IDLE/WAIT/DONE.
  - Write-encoder byte-enable constants, so encoder and decoder share lane definitions.
- One combinational sub-module, read_lane_extract (memData, offset, dataSize, signExt -> 32-bit result). The FSM, counter and output registers stay in the top level.

## Test plan
- Byte load, offset 1, memData 0x8899AABB, memReady in cycle 1:
  - signExt = 1 -> outData 0xFFFFFF99, dataValid in cycle 2.
  - signExt = 0 -> outData 0x00000099.
- Half loads on 0x8899AABB:
  - Offset 0, signExt = 0 -> 0x00008899.
  - Offset 2, signExt = 1 -> 0xFFFFAABB.
- Word load, memReady first high in cycle 4 -> memReq high cycles 1-4, outData 0x8899AABB with dataValid in cycle 5 only.
- TIMEOUT = 8, memReady held low -> memReq high cycles 1-8, dataValid with error = 1 and outData 0 in cycle 9, IDLE in cycle 10.
- Reset and ignored requests:
  - rst in cycle 2 of WAIT -> memReq 0 and state IDLE from cycle 3, no dataValid.
  - A second memRead asserted during WAIT -> not accepted.
- dataSize 3 -> error in cycle 1, memReq never asserted.
- With MEM_READ_ALIGN_CHECK_EN, half at offset 1 -> same error response as dataSize 3.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: encodings shared by the store encoder and the load decoder.
// It holds the size codes, the load FSM states, and the big-endian
// byte-enable lane definitions that both sides of the memory path use.
package mem_access_pkg;

    localparam logic [1:0] SIZE_WORD    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_BYTE    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } memState_t;

    // Byte enables, bit 3 = bits [31:24] (big-endian lane 0).
    localparam logic [3:0] BE_BYTE0 = 4'b1000;
    localparam logic [3:0] BE_BYTE1 = 4'b0100;
    localparam logic [3:0] BE_BYTE2 = 4'b0010;
    localparam logic [3:0] BE_BYTE3 = 4'b0001;
    localparam logic [3:0] BE_HALF0 = 4'b1100;
    localparam logic [3:0] BE_HALF1 = 4'b0011;
    localparam logic [3:0] BE_WORD  = 4'b1111;
    localparam logic [3:0] BE_NONE  = 4'b0000;

    // Lanes touched by an access; a nonzero half offset maps to the low half.
    function automatic logic [3:0] laneEnable(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        be = BE_NONE;
        case (size)
            SIZE_WORD: be = BE_WORD;
            SIZE_HALF: be = (offset == 2'd0) ? BE_HALF0 : BE_HALF1;
            SIZE_BYTE: begin
                case (offset)
                    2'd0:    be = BE_BYTE0;
                    2'd1:    be = BE_BYTE1;
                    2'd2:    be = BE_BYTE2;
                    default: be = BE_BYTE3;
                endcase
            end
            default:   be = BE_NONE;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_read_data_decoder_lane_extract.sv
// read_lane_extract: picks the addressed byte/half/word out of a big-endian
// memory word and zero- or sign-extends it to 32 bits. Purely combinational.
module read_lane_extract
    import mem_access_pkg::*;
(
    input  logic [31:0] memData,
    input  logic [1:0]  offset,
    input  logic [1:0]  dataSize,
    input  logic        signExt,
    output logic [31:0] result
);

    logic [3:0]  laneEn;
    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Select the lane through the shared byte enables, then extend it.
    always_comb begin
        laneEn   = laneEnable(dataSize, offset);
        byteLane = 8'h00;
        halfLane = 16'h0000;
        result   = 32'h0000_0000;
        case (laneEn)
            BE_BYTE0: byteLane = memData[31:24];
            BE_BYTE1: byteLane = memData[23:16];
            BE_BYTE2: byteLane = memData[15:8];
            BE_BYTE3: byteLane = memData[7:0];
            BE_HALF0: halfLane = memData[31:16];
            BE_HALF1: halfLane = memData[15:0];
            default:  ;
        endcase
        case (dataSize)
            SIZE_WORD: result = memData;
            SIZE_HALF: result = {{16{signExt & halfLane[15]}}, halfLane};
            SIZE_BYTE: result = {{24{signExt & byteLane[7]}}, byteLane};
            default:   result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_read_data_decoder.sv
// mem_read_data_decoder: load-side memory read sequencer.
// Accepts one load in IDLE, holds memReq through WAIT until memReady or a
// timeout, then presents the decoded result for one cycle in DONE.
// Optional macro MEM_READ_ALIGN_CHECK_EN: misaligned half/word loads are
// rejected with an error instead of being read.
//
// state | meaning
// IDLE  | waiting for memRead
// WAIT  | memReq high, waiting for memReady or timeout
// DONE  | dataValid pulse with result or error
module mem_read_data_decoder
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic [1:0]  offset,
    input  logic [1:0]  dataSize,
    input  logic        signExt,
    output logic        busy,
    output logic        memReq,
    input  logic        memReady,
    input  logic [31:0] memData,
    output logic [31:0] outData,
    output logic        dataValid,
    output logic        error
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    memState_t   state;
    logic [CW-1:0] waitCount;
    logic [1:0]  reqOffset;
    logic [1:0]  reqSize;
    logic        reqSignExt;
    logic        illegalReq;
    logic [31:0] decoded;

    read_lane_extract uExtract (
        .memData  (memData),
        .offset   (reqOffset),
        .dataSize (reqSize),
        .signExt  (reqSignExt),
        .result   (decoded)
    );

    // Classify the incoming request before it is accepted.
    always_comb begin
        illegalReq = (dataSize == SIZE_ILLEGAL);
`ifdef MEM_READ_ALIGN_CHECK_EN
        if ((dataSize == SIZE_HALF) && offset[0])
            illegalReq = 1'b1;
        if ((dataSize == SIZE_WORD) && (offset != 2'd0))
            illegalReq = 1'b1;
`endif
    end

    // Load sequencer with registered outputs and wait-state counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            memReq     <= 1'b0;
            dataValid  <= 1'b0;
            error      <= 1'b0;
            outData    <= 32'h0000_0000;
            waitCount  <= '0;
            reqOffset  <= 2'd0;
            reqSize    <= 2'd0;
            reqSignExt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (memRead) begin
                        reqOffset  <= offset;
                        reqSize    <= dataSize;
                        reqSignExt <= signExt;
                        busy       <= 1'b1;
                        if (illegalReq) begin
                            state     <= ST_DONE;
                            dataValid <= 1'b1;
                            error     <= 1'b1;
                            outData   <= 32'h0000_0000;
                        end else begin
                            state     <= ST_WAIT;
                            memReq    <= 1'b1;
                            waitCount <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (memReady) begin
                        state     <= ST_DONE;
                        memReq    <= 1'b0;
                        dataValid <= 1'b1;
                        error     <= 1'b0;
                        outData   <= decoded;
                    end else if ((TIMEOUT != 0) && (waitCount == LAST_COUNT)) begin
                        state     <= ST_DONE;
                        memReq    <= 1'b0;
                        dataValid <= 1'b1;
                        error     <= 1'b1;
                        outData   <= 32'h0000_0000;
                    end else begin
                        waitCount <= waitCount + CW'(1);
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    dataValid <= 1'b0;
                    error     <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    memReq    <= 1'b0;
                    dataValid <= 1'b0;
                    error     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_data_decoder.sv
// Bench for mem_read_data_decoder: directed loads against a cycle-expectation
// model derived from the load rules, plus hand-computed result literals.
module tb_mem_read_data_decoder;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead;
    logic [1:0]  offset;
    logic [1:0]  dataSize;
    logic        signExt;
    logic        busy;
    logic        memReq;
    logic        memReady;
    logic [31:0] memData;
    logic [31:0] outData;
    logic        dataValid;
    logic        error;

    int vectors = 0;
    int miscompares = 0;
    int validCount = 0;

    bit          checkEn = 1'b0;
    logic        eBusy = 1'b0;
    logic        eReq = 1'b0;
    logic        eValid = 1'b0;
    logic        eErr = 1'b0;
    logic [31:0] eData = 32'h0;
    logic [31:0] capData = 32'h0;
    logic        capErr = 1'b0;

    mem_read_data_decoder #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .memRead   (memRead),
        .offset    (offset),
        .dataSize  (dataSize),
        .signExt   (signExt),
        .busy      (busy),
        .memReq    (memReq),
        .memReady  (memReady),
        .memData   (memData),
        .outData   (outData),
        .dataValid (dataValid),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Result of a load as the rules describe it: {error, data}.
    function automatic logic [32:0] modelLoad(input logic [31:0] d, input int off, input int size, input bit sx);
        bit illegal;
        logic [31:0] v;
        int unsigned h;
        int unsigned b;
        illegal = (size == 3);
`ifdef MEM_READ_ALIGN_CHECK_EN
        if (size == 1 && (off % 2) == 1) illegal = 1'b1;
        if (size == 0 && off != 0) illegal = 1'b1;
`endif
        v = 32'h0;
        if (!illegal) begin
            if (size == 0) begin
                v = d;
            end else if (size == 1) begin
                h = (off == 0) ? (d / 65536) : (d % 65536);
                v = (sx && h >= 32768) ? (h + 32'hFFFF0000) : h;
            end else begin
                b = (d >> (8 * (3 - off))) & 32'hFF;
                v = (sx && b >= 128) ? (b + 32'hFFFFFF00) : b;
            end
        end
        return {illegal, v};
    endfunction

    // Compare process: every cycle, DUT outputs against the expectation.
    always @(negedge clk) begin
        if (checkEn) begin
            check("busy", 64'(busy), 64'(eBusy));
            check("memReq", 64'(memReq), 64'(eReq));
            check("dataValid", 64'(dataValid), 64'(eValid));
            check("outData", 64'(outData), 64'(eData));
            if (dataValid) begin
                check("error", 64'(error), 64'(eErr));
                capData = outData;
                capErr  = error;
                validCount++;
            end
        end
    end

    task automatic scramble();
        offset   = 2'($urandom);
        dataSize = 2'($urandom);
        signExt  = 1'($urandom);
    endtask

    // One load; readyAt = cycle memReady is raised (0 = never), lit = expected {error,data}.
    task automatic runLoad(input string name, input logic [1:0] off, input logic [1:0] size, input bit sx,
                           input logic [31:0] data, input int readyAt, input logic [32:0] lit);
        logic [32:0] m;
        int c;
        bit done;
        bit timedOut;
        int validBefore;
        m = modelLoad(data, int'(off), int'(size), sx);
        validBefore = validCount;
        @(posedge clk); #1;
        memRead = 1'b1; offset = off; dataSize = size; signExt = sx;
        memReady = 1'b0; memData = $urandom;
        eBusy = 1'b0; eReq = 1'b0; eValid = 1'b0;
        if (m[32]) begin
            @(posedge clk); #1;
            memRead = 1'b0; scramble();
            eBusy = 1'b1; eReq = 1'b0; eValid = 1'b1; eErr = 1'b1; eData = 32'h0;
        end else begin
            c = 1; done = 1'b0; timedOut = 1'b0;
            while (!done) begin
                @(posedge clk); #1;
                memRead = (c == 2); scramble();
                eBusy = 1'b1; eReq = 1'b1; eValid = 1'b0;
                if (c == readyAt) begin
                    memReady = 1'b1; memData = data; done = 1'b1;
                end else begin
                    memReady = 1'b0; memData = $urandom;
                    if (c == TMO || c > 200) begin
                        done = 1'b1; timedOut = 1'b1;
                    end
                end
                c++;
            end
            @(posedge clk); #1;
            memRead = 1'b0; memReady = 1'b1; memData = $urandom;
            eBusy = 1'b1; eReq = 1'b0; eValid = 1'b1;
            eErr  = timedOut;
            eData = timedOut ? 32'h0 : m[31:0];
        end
        @(posedge clk); #1;
        memReady = 1'b0;
        eBusy = 1'b0; eReq = 1'b0; eValid = 1'b0;
        check({name, "_count"}, 64'(validCount - validBefore), 64'd1);
        check({name, "_lit"}, 64'({capErr, capData}), 64'(lit));
    endtask

    initial begin
        rst = 1'b1; memRead = 1'b0; offset = 2'd0; dataSize = 2'd0; signExt = 1'b0;
        memReady = 1'b0; memData = 32'h0;
        @(posedge clk); #1;
        checkEn = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        memReady = 1'b1;
        @(posedge clk); #1;
        memReady = 1'b0;

        runLoad("byteSx",    2'd1, 2'd2, 1'b1, 32'h8899AABB, 1, {1'b0, 32'hFFFFFF99});
        runLoad("byteZx",    2'd1, 2'd2, 1'b0, 32'h8899AABB, 1, {1'b0, 32'h00000099});
        runLoad("halfOff0",  2'd0, 2'd1, 1'b0, 32'h8899AABB, 1, {1'b0, 32'h00008899});
        runLoad("halfOff2",  2'd2, 2'd1, 1'b1, 32'h8899AABB, 3, {1'b0, 32'hFFFFAABB});
        runLoad("wordWait4", 2'd0, 2'd0, 1'b1, 32'h8899AABB, 4, {1'b0, 32'h8899AABB});
        runLoad("byteOff3",  2'd3, 2'd2, 1'b1, 32'h12345680, 2, {1'b0, 32'hFFFFFF80});
        runLoad("byteOff0",  2'd0, 2'd2, 1'b1, 32'h7F00FFFF, 1, {1'b0, 32'h0000007F});
        runLoad("timeout",   2'd0, 2'd0, 1'b0, 32'h8899AABB, 0, {1'b1, 32'h0});
        runLoad("readyLast", 2'd0, 2'd0, 1'b0, 32'h8899AABB, TMO, {1'b0, 32'h8899AABB});
        runLoad("size3",     2'd0, 2'd3, 1'b0, 32'h8899AABB, 1, {1'b1, 32'h0});
`ifdef MEM_READ_ALIGN_CHECK_EN
        runLoad("halfOff1",  2'd1, 2'd1, 1'b1, 32'h8899AABB, 2, {1'b1, 32'h0});
        runLoad("wordOff2",  2'd2, 2'd0, 1'b0, 32'h8899AABB, 1, {1'b1, 32'h0});
`else
        runLoad("halfOff1",  2'd1, 2'd1, 1'b1, 32'h8899AABB, 2, {1'b0, 32'hFFFFAABB});
        runLoad("wordOff2",  2'd2, 2'd0, 1'b0, 32'h8899AABB, 1, {1'b0, 32'h8899AABB});
`endif

        // Reset during WAIT drops the access.
        begin
            int validBefore;
            validBefore = validCount;
            @(posedge clk); #1;
            memRead = 1'b1; offset = 2'd0; dataSize = 2'd0; signExt = 1'b0;
            eBusy = 1'b0; eReq = 1'b0; eValid = 1'b0;
            @(posedge clk); #1;
            memRead = 1'b0;
            eBusy = 1'b1; eReq = 1'b1;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; memReady = 1'b1; memData = 32'hDEADBEEF;
            eBusy = 1'b0; eReq = 1'b0; eValid = 1'b0; eData = 32'h0;
            @(posedge clk); #1;
            memReady = 1'b0;
            @(posedge clk); #1;
            check("rstNoValid", 64'(validCount - validBefore), 64'd0);
        end

        runLoad("afterRst",  2'd2, 2'd2, 1'b0, 32'h8899AABB, 1, {1'b0, 32'h000000AA});

        @(posedge clk); #1;
        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
